// File: rtl/free_list.sv
`default_nettype none
// ============================================================================
//  Module   : free_list
//  Purpose  : Physical-register free list for rename/dispatch. A circular FIFO
//             of free preg indices. It offers up to two pregs per cycle to
//             dispatch and takes back the old prd of each retiring
//             instruction. A flush rewinds the speculative head to the
//             architectural head, which recovers every speculative
//             allocation.
//  Ports    : clock, reset_n            - clock, synchronous active-low reset
//             disp2fl_alloc{0,1}_en     - dispatch consumes the offered preg
//             fl2disp_alloc{0,1}_prd    - pregs offered to instr0 / instr1
//             fl2disp_can_alloc         - at least two entries are free
//             rob2fl_commit{0,1}_en     - retiring slot frees its old prd
//             rob2fl_commit{0,1}_old_prd- preg returned by that slot
//             flush_valid               - discard speculative allocations
//             fl2dbg_free_count         - number of free entries
//  Revision : 1.0 - initial release
// ============================================================================
module free_list #(
   parameter int NUM_PREG = 64,
   parameter int NUM_AREG = 32,
   parameter int DEPTH    = NUM_PREG - NUM_AREG,
   parameter int PW       = $clog2(NUM_PREG),
   parameter int PTRW     = $clog2(DEPTH) + 1
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            disp2fl_alloc0_en,
   input  logic            disp2fl_alloc1_en,
   output logic [PW-1:0]   fl2disp_alloc0_prd,
   output logic [PW-1:0]   fl2disp_alloc1_prd,
   output logic            fl2disp_can_alloc,
   input  logic            rob2fl_commit0_en,
   input  logic [PW-1:0]   rob2fl_commit0_old_prd,
   input  logic            rob2fl_commit1_en,
   input  logic [PW-1:0]   rob2fl_commit1_old_prd,
   input  logic            flush_valid,
   output logic [PTRW-1:0] fl2dbg_free_count
);

   localparam int IW = PTRW - 1;

   logic [PW-1:0]   mem [DEPTH];
   logic [PTRW-1:0] spec_head;
   logic [PTRW-1:0] arch_head;
   logic [PTRW-1:0] tail;

   logic [PTRW-1:0] count;
   logic            can_alloc;
   logic [IW-1:0]   head_idx;
   logic [IW-1:0]   head_nxt_idx;
   logic [IW-1:0]   tail_idx;
   logic [IW-1:0]   tail_nxt_idx;
   logic [PTRW-1:0] nalloc;
   logic [PTRW-1:0] ncommit;
   logic [PW-1:0]   first_prd;

   // Pointers carry one extra wrap bit, so plain subtraction gives occupancy.
   assign count        = tail - spec_head;
   assign can_alloc    = (count >= PTRW'(2));
   assign head_idx     = spec_head[IW-1:0];
   assign head_nxt_idx = head_idx + IW'(1);
   assign tail_idx     = tail[IW-1:0];
   assign tail_nxt_idx = tail_idx + IW'(1);

   // An alloc1-only cycle consumes the head slot, so instr1 sees mem[head].
   assign fl2disp_alloc0_prd = mem[head_idx];
   assign fl2disp_alloc1_prd = disp2fl_alloc0_en ? mem[head_nxt_idx] : mem[head_idx];
   assign fl2disp_can_alloc  = can_alloc;
   assign fl2dbg_free_count  = count;

   // Alloc requests are dropped unless two entries are free.
   assign nalloc  = can_alloc ? (PTRW'(disp2fl_alloc0_en) + PTRW'(disp2fl_alloc1_en))
                              : '0;
   assign ncommit = PTRW'(rob2fl_commit0_en) + PTRW'(rob2fl_commit1_en);

   // The oldest enabled commit slot lands at tail; slot1 follows it if both fire.
   assign first_prd = rob2fl_commit0_en ? rob2fl_commit0_old_prd : rob2fl_commit1_old_prd;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= PW'(NUM_AREG + i);
         end
         spec_head <= '0;
         arch_head <= '0;
         tail      <= PTRW'(DEPTH);
      end else begin
         if (rob2fl_commit0_en || rob2fl_commit1_en) begin
            mem[tail_idx] <= first_prd;
         end
         if (rob2fl_commit0_en && rob2fl_commit1_en) begin
            mem[tail_nxt_idx] <= rob2fl_commit1_old_prd;
         end
         tail      <= tail + ncommit;
         arch_head <= arch_head + ncommit;
         // Flush rewinds past this cycle's commits; new allocs are discarded.
         if (flush_valid) begin
            spec_head <= arch_head + ncommit;
         end else begin
            spec_head <= spec_head + nalloc;
         end
      end
   end

`ifndef SYNTHESIS
   logic [PTRW-1:0] outstanding;
   assign outstanding = spec_head - arch_head;

   always_ff @(posedge clock) begin
      if (reset_n) begin
         assert (count <= PTRW'(DEPTH))
            else $error("free_list: free count exceeds depth");
         assert (ncommit <= outstanding)
            else $error("free_list: commit retires more than were allocated");
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_free_list.sv
`default_nettype none
// ============================================================================
//  Module   : tb_free_list
//  Purpose  : Self-checking bench for free_list: a directed vector table,
//             hand-written full/wrap sequences, and randomized traffic checked
//             against a queue-based model of free and in-flight pregs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_free_list;

   logic       clock;
   logic       reset_n;
   logic       a0, a1;
   logic [5:0] prd0, prd1;
   logic       can;
   logic       c0, c1;
   logic [5:0] p0, p1;
   logic       fl;
   logic [5:0] cnt;

   int n_cmp = 0;
   int n_err = 0;

   free_list dut (
      .clock                  (clock),
      .reset_n                (reset_n),
      .disp2fl_alloc0_en      (a0),
      .disp2fl_alloc1_en      (a1),
      .fl2disp_alloc0_prd     (prd0),
      .fl2disp_alloc1_prd     (prd1),
      .fl2disp_can_alloc      (can),
      .rob2fl_commit0_en      (c0),
      .rob2fl_commit0_old_prd (p0),
      .rob2fl_commit1_en      (c1),
      .rob2fl_commit1_old_prd (p1),
      .flush_valid            (fl),
      .fl2dbg_free_count      (cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at time limit");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic       rst_n, a0, a1, c0;
      logic [5:0] p0;
      logic       c1;
      logic [5:0] p1;
      logic       fl;
      int         e0, e1;
      logic       ecan;
      int         ecnt;
   } vec_t;

   vec_t tbl [13];

   // Reference model: pregs free for allocation (in offer order) and pregs
   // allocated but not yet retired (oldest first).
   int free_q[$];
   int infl_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic x0, input logic x1,
                        input logic y0, input logic [5:0] q0,
                        input logic y1, input logic [5:0] q1, input logic f);
      reset_n = r; a0 = x0; a1 = x1; c0 = y0; p0 = q0; c1 = y1; p1 = q1; fl = f;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic vec_t mk(logic r, logic x0, logic x1, logic y0, logic [5:0] q0,
                               logic y1, logic [5:0] q1, logic f,
                               int e0, int e1, logic ec, int en);
      vec_t v;
      v.rst_n = r; v.a0 = x0; v.a1 = x1; v.c0 = y0; v.p0 = q0;
      v.c1 = y1; v.p1 = q1; v.fl = f;
      v.e0 = e0; v.e1 = e1; v.ecan = ec; v.ecnt = en;
      return v;
   endfunction

   task automatic model_reset();
      free_q.delete();
      infl_q.delete();
      for (int i = 0; i < 32; i++) free_q.push_back(32 + i);
   endtask

   task automatic model_step();
      bit ok;
      int n;
      if (!reset_n) begin
         model_reset();
         return;
      end
      ok = (free_q.size() >= 2);
      n  = int'(c0) + int'(c1);
      repeat (n) void'(infl_q.pop_front());
      if (fl) begin
         while (infl_q.size() > 0) free_q.push_front(infl_q.pop_back());
      end else if (ok) begin
         if (a0 && a1) begin
            infl_q.push_back(free_q.pop_front());
            infl_q.push_back(free_q.pop_front());
         end else if (a0 || a1) begin
            infl_q.push_back(free_q.pop_front());
         end
      end
      if (c0) free_q.push_back(int'(p0));
      if (c1) free_q.push_back(int'(p1));
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
      tick();
      tick();

      // ---------------- directed vector table ----------------
      tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0,  0, 32, 32, 1, 32);
      tbl[1]  = mk(1, 1, 1, 0, 0, 0, 0,  0, 32, 33, 1, 32);
      tbl[2]  = mk(1, 0, 1, 0, 0, 0, 0,  0, 34, 34, 1, 30);
      tbl[3]  = mk(1, 1, 0, 0, 0, 0, 0,  0, 35, 36, 1, 29);
      tbl[4]  = mk(1, 1, 1, 1, 3, 0, 0,  1, 36, 37, 1, 28);
      tbl[5]  = mk(1, 0, 0, 0, 0, 0, 0,  0, 33, 33, 1, 32);
      tbl[6]  = mk(0, 1, 1, 1, 9, 1, 10, 1, 33, 34, 1, 32);
      tbl[7]  = mk(1, 0, 1, 0, 0, 0, 0,  0, 32, 32, 1, 32);
      tbl[8]  = mk(1, 0, 0, 0, 0, 0, 0,  0, 33, 33, 1, 31);
      tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 33, 33, 1, 31);
      tbl[10] = mk(1, 1, 0, 0, 0, 0, 0,  0, 32, 33, 1, 32);
      tbl[11] = mk(1, 0, 0, 0, 0, 1, 12, 0, 33, 33, 1, 31);
      tbl[12] = mk(1, 0, 0, 0, 0, 0, 0,  0, 33, 33, 1, 32);

      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].rst_n, tbl[i].a0, tbl[i].a1, tbl[i].c0, tbl[i].p0,
               tbl[i].c1, tbl[i].p1, tbl[i].fl);
         @(negedge clock);
         check($sformatf("tbl%0d_prd0", i),  32'(prd0), 32'(tbl[i].e0));
         check($sformatf("tbl%0d_prd1", i),  32'(prd1), 32'(tbl[i].e1));
         check($sformatf("tbl%0d_can", i),   32'(can),  32'(tbl[i].ecan));
         check($sformatf("tbl%0d_count", i), 32'(cnt),  32'(tbl[i].ecnt));
         tick();
      end

      // ---------------- drain to empty, ignored alloc, wrap ----------------
      drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
      tick();
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
         tick();
      end
      drive(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
      @(negedge clock);
      check("empty_count", 32'(cnt), 32'd0);
      check("empty_can",   32'(can), 32'd0);
      tick();
      drive(1'b1, 1'b1, 1'b0, 1'b1, 6'd5, 1'b0, 6'd0, 1'b0);
      @(negedge clock);
      check("alloc_ignored_count", 32'(cnt), 32'd0);
      tick();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 6'd7, 1'b0);
      @(negedge clock);
      check("one_free_count", 32'(cnt), 32'd1);
      check("one_free_can",   32'(can), 32'd0);
      tick();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
      @(negedge clock);
      check("wrap_count", 32'(cnt),  32'd2);
      check("wrap_can",   32'(can),  32'd1);
      check("wrap_prd0",  32'(prd0), 32'd5);
      check("wrap_prd1",  32'(prd1), 32'd7);
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
      @(negedge clock);
      check("wrap_consumed_count", 32'(cnt), 32'd0);
      tick();

      // ---------------- randomized traffic vs model ----------------
      drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
      tick();
      model_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic r, x0, x1, y0, y1, f;
         logic [5:0] q0, q1;
         int avail;
         r = ($urandom_range(0, 199) != 0);
         if (free_q.size() >= 2) begin
            x0 = 1'($urandom_range(0, 1));
            x1 = 1'($urandom_range(0, 1));
         end else begin
            x0 = ($urandom_range(0, 3) == 0);
            x1 = ($urandom_range(0, 3) == 0);
         end
         y0 = 1'($urandom_range(0, 1));
         y1 = 1'($urandom_range(0, 1));
         avail = infl_q.size();
         if (r) begin
            if (avail == 0) begin
               y0 = 1'b0; y1 = 1'b0;
            end else if (avail == 1 && y0 && y1) begin
               y1 = 1'b0;
            end
         end
         q0 = 6'($urandom_range(0, 63));
         q1 = 6'($urandom_range(0, 63));
         f  = ($urandom_range(0, 15) == 0);
         drive(r, x0, x1, y0, q0, y1, q1, f);
         @(negedge clock);
         check("rnd_count", 32'(cnt), 32'(free_q.size()));
         check("rnd_can",   32'(can), 32'(free_q.size() >= 2));
         if (free_q.size() >= 1)
            check("rnd_prd0", 32'(prd0), 32'(free_q[0]));
         if (x0 && free_q.size() >= 2)
            check("rnd_prd1", 32'(prd1), 32'(free_q[1]));
         else if (!x0 && free_q.size() >= 1)
            check("rnd_prd1", 32'(prd1), 32'(free_q[0]));
         model_step();
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
